calc_unit_seq: RTL and testbench

Parametrised, registered successor to the team's combinational 16-bit signed calculator.
- Signed operand width is generic; operands are accepted through a valid/ready handshake.
- Results are held in a registered output stage until consumed.
- Adds optional saturation, a true two-operand multi-cycle divider, and an error flag.
- Sits between the operand/opcode sequencer and the result display/register-file logic.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_unit_seq_if.sv | 25 ++
 rtl/calc_div_iter.sv | 80 ++++++++
 rtl/calc_unit_seq.sv | 143 ++++++++++++++
 tb/tb_calc_unit_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared opcode map, FSM encoding and range helpers for the sequential calculator.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_SRA = 4'hA;
  localparam logic [3:0] OP_MOD = 4'hB;

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  // Two's-complement MIN/MAX of a w-bit signed value, in the low w bits.
  function automatic logic [63:0] min_of(input int unsigned w);
    return 64'hFFFF_FFFF_FFFF_FFFF << (w - 1);
  endfunction

  function automatic logic [63:0] max_of(input int unsigned w);
    return ~min_of(w);
  endfunction

endpackage

// File: rtl/calc_unit_seq_if.sv
// Operand/result handshake bundle between sequencer (master) and calculator (slave).
interface calc_unit_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in1;
  logic signed [WIDTH-1:0] in2;
  logic [3:0]              opCode;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] result;
  logic                    overflow;
  logic                    err;

  modport master (
    output in_valid, in1, in2, opCode, out_ready,
    input  in_ready, out_valid, result, overflow, err
  );

  modport slave (
    input  in_valid, in1, in2, opCode, out_ready,
    output in_ready, out_valid, result, overflow, err
  );
endinterface

// File: rtl/calc_div_iter.sv
// Iterative signed divider: restoring shift-subtract on magnitudes, one quotient bit per cycle.
module calc_div_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, den_q, den_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [WIDTH:0]   shifted, diff;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, den_q};
    quo_d   = quo_q;
    rem_d   = rem_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (start) begin
      quo_d  = mag(dividend);
      rem_d  = '0;
      den_d  = mag(divisor);
      cnt_d  = '0;
      busy_d = 1'b1;
      qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_d = dividend[WIDTH-1];
    end else if (busy_q) begin
      // A borrow out of the trial subtraction means the divisor did not fit.
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == LastCnt) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

  // Results are taken from the final iteration's next-state so the caller can latch them at once.
  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == LastCnt);
  assign quotient  = qneg_q ? -quo_d : quo_d;
  assign remainder = rneg_q ? -rem_d : rem_d;

endmodule

// File: rtl/calc_unit_seq.sv
// Registered signed calculator: single-cycle ALU ops plus iterative divide/modulo behind a handshake.
module calc_unit_seq
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b0
) (
  input logic            clk,
  input logic            rst,
  calc_unit_seq_if.slave bus
);
  localparam logic [WIDTH-1:0] MinV = WIDTH'(min_of(WIDTH));
  localparam logic [WIDTH-1:0] MaxV = WIDTH'(max_of(WIDTH));

  state_e state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, alu_res, div_res, quo, rem;
  logic ovf_q, ovf_d, err_q, err_d, is_mod_q, is_mod_d, mn1_q, mn1_d;
  logic alu_ovf, alu_err, div_ovf, accept, div_start, div_busy, div_done, use_ex, mul_ovf;
  logic [WIDTH:0] a_x, b_x, ex;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH:0] mul_hi;

  assign accept    = bus.in_valid && bus.in_ready;
  assign div_start = accept && (bus.opCode == OP_DIV || bus.opCode == OP_MOD) && (|bus.in2);
  assign a_x       = {bus.in1[WIDTH-1], bus.in1};
  assign b_x       = {bus.in2[WIDTH-1], bus.in2};
  assign prod      = (2*WIDTH)'(bus.in1) * (2*WIDTH)'(bus.in2);
  assign mul_hi    = prod[2*WIDTH-1:WIDTH-1];
  assign mul_ovf   = !((&mul_hi) || !(|mul_hi));

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    ex      = '0;
    use_ex  = 1'b0;
    case (bus.opCode)
      OP_ADD: begin ex = a_x + b_x; use_ex = 1'b1; end
      OP_SUB: begin ex = a_x - b_x; use_ex = 1'b1; end
      OP_INC: begin ex = a_x + (WIDTH+1)'(1); use_ex = 1'b1; end
      OP_DEC: begin ex = a_x - (WIDTH+1)'(1); use_ex = 1'b1; end
      OP_MUL: begin
        alu_ovf = mul_ovf;
        alu_res = (SATURATE && mul_ovf) ? (prod[2*WIDTH-1] ? MinV : MaxV) : prod[WIDTH-1:0];
      end
      OP_AND: alu_res = bus.in1 & bus.in2;
      OP_XOR: alu_res = bus.in1 ^ bus.in2;
      OP_OR:  alu_res = bus.in1 | bus.in2;
      OP_NOT: alu_res = ~bus.in1;
      OP_SRA: alu_res = bus.in1 >>> bus.in2[3:0];
      OP_DIV, OP_MOD: alu_err = ~(|bus.in2);
      default: alu_err = 1'b1;
    endcase
    if (use_ex) begin
      alu_ovf = ex[WIDTH] ^ ex[WIDTH-1];
      alu_res = (SATURATE && alu_ovf) ? (ex[WIDTH] ? MinV : MaxV) : ex[WIDTH-1:0];
    end
  end

  calc_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (bus.in1),
    .divisor  (bus.in2),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quo),
    .remainder(rem)
  );

  // MIN / -1 is the one quotient that cannot be represented.
  always_comb begin
    div_res = is_mod_q ? rem : quo;
    div_ovf = 1'b0;
    if (!is_mod_q) begin
      if (mn1_q) begin
        div_ovf = 1'b1;
        div_res = SATURATE ? MaxV : MinV;
      end else begin
        div_ovf = |rem;
      end
    end
  end

  always_comb begin
    res_d    = res_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    is_mod_d = is_mod_q;
    mn1_d    = mn1_q;
    if (accept) begin
      res_d    = alu_res;
      ovf_d    = alu_ovf;
      err_d    = alu_err;
      is_mod_d = (bus.opCode == OP_MOD);
      mn1_d    = (bus.in1 == MinV) && (&bus.in2);
    end else if (state_q == StDiv && div_done) begin
      res_d = div_res;
      ovf_d = div_ovf;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      is_mod_q <= 1'b0;
      mn1_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      is_mod_q <= is_mod_d;
      mn1_q    <= mn1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = div_start ? StDiv : StDone;
      StDiv:   if (div_done) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle) && !div_busy;
    bus.out_valid = (state_q == StDone);
    bus.result    = res_q;
    bus.overflow  = ovf_q;
    bus.err       = err_q;
  end

endmodule

// File: tb/tb_calc_unit_seq.sv
// Scoreboard bench: wrapping and saturating instances driven in lockstep with directed vectors.
module tb_calc_unit_seq;
  import calc_pkg::*;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  calc_unit_seq_if #(.WIDTH(W)) bus_w ();
  calc_unit_seq_if #(.WIDTH(W)) bus_s ();

  calc_unit_seq #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(bus_w.slave));
  calc_unit_seq #(.WIDTH(W), .SATURATE(1'b1)) u_sat  (.clk(clk), .rst(rst), .bus(bus_s.slave));

  typedef struct {
    logic [3:0] op;
    int a; int b; int ew; int es;
    bit ovf; bit err; int lat;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    bit ovf; bit err; int lat; int unsigned acc;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];

  // op, in1, in2, wrap result, saturated result, overflow, err, latency
  vec_t vecs [22] = '{
    '{OP_ADD, 32767, 1, -32768, 32767, 1, 0, 1},
    '{OP_ADD, 100, -30, 70, 70, 0, 0, 1},
    '{OP_SUB, -32768, 1, 32767, -32768, 1, 0, 1},
    '{OP_SUB, 5, 9, -4, -4, 0, 0, 1},
    '{OP_MUL, 300, 200, -5536, 32767, 1, 0, 1},
    '{OP_MUL, -3, 7, -21, -21, 0, 0, 1},
    '{OP_MUL, -300, 200, 5536, -32768, 1, 0, 1},
    '{OP_DIV, -47, 10, -4, -4, 1, 0, 17},
    '{OP_MOD, -47, 10, -7, -7, 0, 0, 17},
    '{OP_DIV, 100, 0, 0, 0, 0, 1, 1},
    '{OP_DIV, -32768, -1, -32768, 32767, 1, 0, 17},
    '{OP_MOD, 47, -10, 7, 7, 0, 0, 17},
    '{OP_DIV, 20, -5, -4, -4, 0, 0, 17},
    '{OP_AND, 'h0F0F, 'h00FF, 'h000F, 'h000F, 0, 0, 1},
    '{OP_XOR, 'h0F0F, 'h00FF, 'h0FF0, 'h0FF0, 0, 0, 1},
    '{OP_OR,  'h0F0F, 'h00FF, 'h0FFF, 'h0FFF, 0, 0, 1},
    '{OP_NOT, 'h0F0F, 0, 'hF0F0, 'hF0F0, 0, 0, 1},
    '{OP_INC, 32767, 0, -32768, 32767, 1, 0, 1},
    '{OP_DEC, -32768, 0, 32767, -32768, 1, 0, 1},
    '{OP_SRA, -256, 'h0014, -16, -16, 0, 0, 1},
    '{4'hF, 1, 2, 0, 0, 0, 1, 1},
    '{OP_MOD, 100, 0, 0, 0, 0, 1, 1}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    bus_w.in_valid = v; bus_w.opCode = op; bus_w.in1 = a; bus_w.in2 = b;
    bus_s.in_valid = v; bus_s.opCode = op; bus_s.in1 = a; bus_s.in2 = b;
  endtask

  task automatic set_out_ready(input logic r);
    bus_w.out_ready = r;
    bus_s.out_ready = r;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!bus_w.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic issue(input vec_t v, input bit expect_out);
    exp_t e;
    @(negedge clk);
    drive(1'b1, v.op, 16'(v.a), 16'(v.b));
    wait_idle();
    chk("in_ready before accept", 32'(bus_w.in_ready), 32'd1);
    if (expect_out) begin
      e.ovf = v.ovf; e.err = v.err; e.lat = v.lat; e.acc = cyc;
      e.res = 16'(v.ew);
      q_w.push_back(e);
      e.res = 16'(v.es);
      q_s.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble inputs after accept: captured operands must not follow them.
    drive(1'b0, 4'(4'hF), 16'($urandom), 16'($urandom));
  endtask

  task automatic mon_step(input string tag, input bit sat, input logic ov, input logic ir,
                          input logic [15:0] res, input logic of, input logic er,
                          inout bit prev, inout logic [15:0] hr, inout logic ho,
                          inout logic he);
    exp_t e;
    bit empty;
    if (ov) begin
      if (!prev) begin
        empty = sat ? (q_s.size() == 0) : (q_w.size() == 0);
        if (empty) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s unexpected output: got result 0x%0h, required no output", tag, res);
        end else begin
          if (sat) e = q_s.pop_front();
          else e = q_w.pop_front();
          chk({tag, " result"}, 32'(res), 32'(e.res));
          chk({tag, " overflow"}, 32'(of), 32'(e.ovf));
          chk({tag, " err"}, 32'(er), 32'(e.err));
          chk({tag, " latency"}, cyc - e.acc, 32'(e.lat));
        end
        hr = res; ho = of; he = er;
      end else begin
        chk({tag, " held result"}, 32'(res), 32'(hr));
        chk({tag, " held overflow"}, 32'(of), 32'(ho));
        chk({tag, " held err"}, 32'(er), 32'(he));
      end
      chk({tag, " in_ready while valid"}, 32'(ir), 32'd0);
    end
    prev = ov;
  endtask

  initial begin : mon_wrap
    bit prev = 1'b0;
    logic [15:0] hr = '0;
    logic ho = 1'b0, he = 1'b0;
    forever begin
      @(negedge clk);
      mon_step("wrap", 1'b0, bus_w.out_valid, bus_w.in_ready, bus_w.result, bus_w.overflow,
               bus_w.err, prev, hr, ho, he);
    end
  end

  initial begin : mon_sat
    bit prev = 1'b0;
    logic [15:0] hr = '0;
    logic ho = 1'b0, he = 1'b0;
    forever begin
      @(negedge clk);
      mon_step("sat", 1'b1, bus_s.out_valid, bus_s.in_ready, bus_s.result, bus_s.overflow,
               bus_s.err, prev, hr, ho, he);
    end
  end

  initial begin : stim
    vec_t v;
    int t;
    drive(1'b0, 4'h0, 16'h0, 16'h0);
    set_out_ready(1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(bus_w.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus_w.out_valid), 32'd0);
    chk("reset result", 32'(bus_w.result), 32'd0);
    chk("reset overflow", 32'(bus_w.overflow), 32'd0);
    chk("reset err", 32'(bus_w.err), 32'd0);
    chk("reset sat in_ready", 32'(bus_s.in_ready), 32'd1);
    rst = 1'b0;

    foreach (vecs[i]) issue(vecs[i], 1'b1);

    // Consumer stalls: outputs must hold and no new op may enter.
    @(negedge clk);
    wait_idle();
    set_out_ready(1'b0);
    v = '{OP_ADD, 2, 3, 5, 5, 0, 0, 1};
    issue(v, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall out_valid", 32'(bus_w.out_valid), 32'd1);
      chk("stall in_ready", 32'(bus_w.in_ready), 32'd0);
      @(negedge clk);
    end
    set_out_ready(1'b1);
    @(posedge clk);
    #1;
    chk("release out_valid", 32'(bus_w.out_valid), 32'd0);
    chk("release in_ready", 32'(bus_w.in_ready), 32'd1);
    v = '{OP_SUB, 10, 3, 7, 7, 0, 0, 1};
    issue(v, 1'b1);

    // Reset mid-divide: the abandoned quotient must never be presented.
    @(negedge clk);
    wait_idle();
    v = '{OP_DIV, 1000, 7, 142, 142, 1, 0, 17};
    issue(v, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort in_ready", 32'(bus_w.in_ready), 32'd1);
    chk("abort out_valid", 32'(bus_w.out_valid), 32'd0);
    chk("abort result", 32'(bus_w.result), 32'd0);
    chk("abort sat result", 32'(bus_s.result), 32'd0);
    repeat (25) @(negedge clk);
    chk("no stale out_valid", 32'(bus_w.out_valid), 32'd0);

    t = 0;
    while ((q_w.size() != 0 || q_s.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("wrap queue drained", 32'(q_w.size()), 32'd0);
    chk("sat queue drained", 32'(q_s.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
